alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_ctrl_pkg.sv | 29 ++
 rtl/arb_rr_pick.sv | 44 ++++
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_ctrl_pkg
// Description : Shared ALU function codes, arbiter FSM state and grant-ID type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b110;
    localparam logic [2:0] F_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef logic grant_id_t;

    // Two-requester one-hot grant collapses to the index of its upper bit.
    function automatic grant_id_t onehot_to_id(input logic [1:0] oh);
        return oh[1];
    endfunction

endpackage : alu_ctrl_pkg
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr_pick
// Description : Two-way grant selection; round-robin when
//               ALU_ARB_ROUND_ROBIN_EN is defined, fixed priority otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_pick
    import alu_ctrl_pkg::*;
(
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  grant_id_t  i_ptr,
    output logic [1:0] o_grant
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        o_grant = 2'b00;
        if (i_valid0 && i_valid1) begin
            o_grant = (i_ptr == 1'b1) ? 2'b01 : 2'b10;
        end else if (i_valid0) begin
            o_grant = 2'b01;
        end else if (i_valid1) begin
            o_grant = 2'b10;
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = i_ptr;

    always_comb begin
        o_grant = 2'b00;
        if (i_valid0) begin
            o_grant = 2'b01;
        end else if (i_valid1) begin
            o_grant = 2'b10;
        end
    end
`endif

endmodule : arb_rr_pick
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one external combinational ALU between two requesters;
//               handshake, issue, response in three cycles.
//               Optional macro: ALU_ARB_ROUND_ROBIN_EN (round-robin grant).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_f,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_f,

    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_y,
    output logic             rsp0_zero,

    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_y,
    output logic             rsp1_zero,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero
);

    state_t           r_state;
    state_t           w_state_nxt;
    grant_id_t        r_last;
    grant_id_t        r_id;
    grant_id_t        w_gid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_f;
    logic [1:0]       w_grant;
    logic             w_idle;
    logic             w_hs;
    logic [WIDTH-1:0] r_rsp0_y;
    logic [WIDTH-1:0] r_rsp1_y;
    logic             r_rsp0_zero;
    logic             r_rsp1_zero;

    arb_rr_pick u_pick (
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_ptr    (r_last),
        .o_grant  (w_grant)
    );

    // Ready is held low while reset is asserted, whatever the current state.
    assign w_idle     = (r_state == IDLE) && !reset;
    assign req0_ready = w_idle && w_grant[0];
    assign req1_ready = w_idle && w_grant[1];
    assign w_hs       = req0_ready || req1_ready;
    assign w_gid      = onehot_to_id(w_grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_b    <= '0;
            r_f    <= '0;
            r_id   <= 1'b0;
            r_last <= 1'b1;
        end else if (w_hs) begin
            r_a    <= w_gid ? req1_a : req0_a;
            r_b    <= w_gid ? req1_b : req0_b;
            r_f    <= w_gid ? req1_f : req0_f;
            r_id   <= w_gid;
            r_last <= w_gid;
        end
    end

    always_comb begin
        alu_a = '0;
        alu_b = '0;
        alu_f = '0;
        if (r_state == ISSUE) begin
            alu_a = r_a;
            alu_b = r_b;
            alu_f = r_f;
        end
    end

    // Per-requester result registers only move when that requester is served.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp0_y    <= '0;
            r_rsp0_zero <= 1'b0;
            r_rsp1_y    <= '0;
            r_rsp1_zero <= 1'b0;
        end else if (r_state == ISSUE) begin
            if (r_id == 1'b0) begin
                r_rsp0_y    <= alu_y;
                r_rsp0_zero <= alu_zero;
            end else begin
                r_rsp1_y    <= alu_y;
                r_rsp1_zero <= alu_zero;
            end
        end
    end

    assign rsp0_valid = (r_state == RESP) && (r_id == 1'b0);
    assign rsp1_valid = (r_state == RESP) && (r_id == 1'b1);
    assign rsp0_y     = r_rsp0_y;
    assign rsp0_zero  = r_rsp0_zero;
    assign rsp1_y     = r_rsp1_y;
    assign rsp1_zero  = r_rsp1_zero;

endmodule : alu_arbiter
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Randomised self-checking bench for alu_arbiter with an
//               external ALU and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_ctrl_pkg::*;

    localparam int WIDTH = 32;

    logic             clk        = 1'b0;
    logic             reset      = 1'b1;
    logic             req0_valid = 1'b0;
    logic             req1_valid = 1'b0;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]       req0_f = '0, req1_f = '0;
    logic             req0_ready, req1_ready;
    logic             rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero;
    logic [WIDTH-1:0] rsp0_y, rsp1_y;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic [2:0]       alu_f;
    logic             alu_zero;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: who won last, and the result each requester should hold.
    logic             exp_last = 1'b1;
    logic [WIDTH-1:0] exp_y [2];
    logic             exp_z [2];

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
        .rsp0_valid(rsp0_valid), .rsp0_y(rsp0_y), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_y(rsp1_y), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
        .alu_y(alu_y), .alu_zero(alu_zero)
    );

    // External combinational ALU; unused codes return a^b.
    always_comb begin
        case (alu_f)
            F_AND:   alu_y = alu_a & alu_b;
            F_OR:    alu_y = alu_a | alu_b;
            F_ADD:   alu_y = alu_a + alu_b;
            F_SUB:   alu_y = alu_a - alu_b;
            F_SLT:   alu_y = ($signed(alu_a) < $signed(alu_b)) ? WIDTH'(1) : '0;
            default: alu_y = alu_a ^ alu_b;
        endcase
    end
    assign alu_zero = (alu_y == '0);

    function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] f,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return WIDTH'(longint'(a) + longint'(b));
            3'b110:  return a + ~b + WIDTH'(1);
            3'b111:  return (sa < sb) ? WIDTH'(1) : WIDTH'(0);
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic model_grant(input logic v0, input logic v1);
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (v0 && v1) return ~exp_last;
`endif
        return v0 ? 1'b0 : 1'b1;
    endfunction

    task automatic set_req(input logic n, input logic v, input logic [2:0] f,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (n == 1'b0) begin
            req0_valid = v; req0_f = f; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_f = f; req1_a = a; req1_b = b;
        end
    endtask

    task automatic new_req(input logic n, input bit force_valid);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        a = WIDTH'($urandom);
        b = ($urandom_range(0, 3) == 0) ? a : WIDTH'($urandom);
        set_req(n, force_valid || ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), a, b);
    endtask

    // One full operation, entered #1 after the edge that starts an idle cycle.
    task automatic txn(input bit keep_valid, input bit rerand);
        logic g, o, z;
        logic [2:0] f;
        logic [WIDTH-1:0] a, b, y;
        if (!req0_valid && !req1_valid) begin
            if ($urandom_range(0, 1) == 1) req1_valid = 1'b1;
            else                           req0_valid = 1'b1;
        end
        g = model_grant(req0_valid, req1_valid);
        o = ~g;
        f = g ? req1_f : req0_f;
        a = g ? req1_a : req0_a;
        b = g ? req1_b : req0_b;
        y = ref_alu(f, a, b);
        z = (y == '0);
        #1;
        vectors++;
        if ({req1_ready, req0_ready} !== (g ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL idle_ready: got %b want %b", {req1_ready, req0_ready}, (g ? 2'b10 : 2'b01));
        end
        @(posedge clk); #1;
        exp_last = g;
        if (rerand) new_req(g, keep_valid);
        #1;
        vectors++;
        if ({alu_f, alu_a, alu_b} !== {f, a, b}) begin
            miscompares++;
            $display("FAIL issue_alu: got f=%b a=%h b=%h want f=%b a=%h b=%h", alu_f, alu_a, alu_b, f, a, b);
        end
        vectors++;
        if ({req1_ready, req0_ready, rsp1_valid, rsp0_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL issue_ctl: got rdy=%b%b rsp=%b%b want all 0", req1_ready, req0_ready, rsp1_valid, rsp0_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if ({rsp1_valid, rsp0_valid} !== (g ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL resp_valid: got %b want %b", {rsp1_valid, rsp0_valid}, (g ? 2'b10 : 2'b01));
        end
        vectors++;
        if ((g ? {rsp1_y, rsp1_zero} : {rsp0_y, rsp0_zero}) !== {y, z}) begin
            miscompares++;
            $display("FAIL resp_data: req%0d f=%b got y=%h z=%b want y=%h z=%b", g, f,
                     (g ? rsp1_y : rsp0_y), (g ? rsp1_zero : rsp0_zero), y, z);
        end
        exp_y[g] = y;
        exp_z[g] = z;
        vectors++;
        if ((o ? {rsp1_y, rsp1_zero} : {rsp0_y, rsp0_zero}) !== {exp_y[o], exp_z[o]}) begin
            miscompares++;
            $display("FAIL resp_other_hold: req%0d got y=%h want y=%h", o, (o ? rsp1_y : rsp0_y), exp_y[o]);
        end
        vectors++;
        if ({alu_f, alu_a, alu_b, req1_ready, req0_ready} !== '0) begin
            miscompares++;
            $display("FAIL resp_quiet: got f=%b a=%h b=%h rdy=%b%b want 0", alu_f, alu_a, alu_b, req1_ready, req0_ready);
        end
        @(posedge clk); #1;
        vectors++;
        if ({rsp1_valid, rsp0_valid, rsp0_y, rsp0_zero, rsp1_y, rsp1_zero} !==
            {2'b00, exp_y[0], exp_z[0], exp_y[1], exp_z[1]}) begin
            miscompares++;
            $display("FAIL idle_hold: got v=%b%b y0=%h y1=%h want v=00 y0=%h y1=%h",
                     rsp1_valid, rsp0_valid, rsp0_y, rsp1_y, exp_y[0], exp_y[1]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        new_req(0, 1'b1);
        new_req(1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got rdy=%b%b v=%b%b z=%b%b want 0", req0_ready, req1_ready,
                     rsp0_valid, rsp1_valid, rsp0_zero, rsp1_zero);
        end
        vectors++;
        if ({rsp0_y, rsp1_y, alu_a, alu_b, alu_f} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got y0=%h y1=%h a=%h b=%h f=%b want 0", rsp0_y, rsp1_y, alu_a, alu_b, alu_f);
        end
        reset    = 1'b0;
        exp_last = 1'b1;
        exp_y[0] = '0; exp_y[1] = '0;
        exp_z[0] = 1'b0; exp_z[1] = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_directed();
        set_req(0, 1'b1, F_ADD, 32'd5, 32'd7);
        set_req(1, 1'b0, F_AND, '0, '0);
        txn(1'b0, 1'b0);
        vectors++;
        if ({rsp0_y, rsp0_zero} !== {32'd12, 1'b0}) begin
            miscompares++;
            $display("FAIL add_5_7: got y=%0d z=%b want y=12 z=0", rsp0_y, rsp0_zero);
        end
        set_req(0, 1'b0, F_AND, '0, '0);
        set_req(1, 1'b1, F_SUB, 32'd9, 32'd9);
        txn(1'b0, 1'b0);
        vectors++;
        if ({rsp1_y, rsp1_zero} !== {32'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL sub_9_9: got y=%0d z=%b want y=0 z=1", rsp1_y, rsp1_zero);
        end
        set_req(0, 1'b1, F_SLT, 32'hFFFF_FFFF, 32'd1);
        set_req(1, 1'b0, F_AND, '0, '0);
        txn(1'b0, 1'b0);
        vectors++;
        if (rsp0_y !== 32'd1) begin
            miscompares++;
            $display("FAIL slt_neg1_1: got y=%h want 1", rsp0_y);
        end
        set_req(0, 1'b1, 3'b100, 32'h0F0F_0F0F, 32'h00FF_00FF);
        txn(1'b0, 1'b0);
        req0_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic want1;
        test_reset();
        new_req(0, 1'b1);
        new_req(1, 1'b1);
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            want1 = (i % 2) == 1;
`else
            want1 = 1'b0;
`endif
            #1;
            vectors++;
            if ({req1_ready, req0_ready} !== {want1, ~want1}) begin
                miscompares++;
                $display("FAIL b2b_grant%0d: got rdy=%b%b want %b%b", i, req1_ready, req0_ready, want1, ~want1);
            end
            txn(1'b1, 1'b1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_random();
        new_req(0, 1'b0);
        new_req(1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            txn(1'b0, 1'b1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_in_issue();
        test_reset();
        new_req(0, 1'b1);
        new_req(1, 1'b1);
        #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rst_issue_ctl: got v=%b%b rdy=%b%b want 0", rsp0_valid, rsp1_valid, req0_ready, req1_ready);
        end
        vectors++;
        if ({rsp0_y, rsp1_y, rsp0_zero, rsp1_zero, alu_a, alu_b, alu_f} !== '0) begin
            miscompares++;
            $display("FAIL rst_issue_data: got y0=%h y1=%h a=%h f=%b want 0", rsp0_y, rsp1_y, alu_a, alu_f);
        end
        reset    = 1'b0;
        exp_last = 1'b1;
        exp_y[0] = '0; exp_y[1] = '0;
        exp_z[0] = 1'b0; exp_z[1] = 1'b0;
        #1;
        vectors++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_issue_regrant: got rdy=%b%b want 01", req1_ready, req0_ready);
        end
        txn(1'b0, 1'b0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_in_issue();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule : tb_alu_arbiter
`default_nettype wire
